// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin using a single full-subtractor cell, LSB first.
// The difference is assembled in a shift register and published only on completion.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
   logic             br_q, bout_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;

   logic             x, y, d_bit, br_d;
   logic [WIDTH-1:0] r_d;

   always_comb begin
      x     = a_q[0];
      y     = b_q[0];
      d_bit = x ^ y ^ br_q;
      br_d  = (~x & y) | (~(x ^ y) & br_q);
      r_d   = {d_bit, r_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               r_q   <= r_d;
               a_q   <= {1'b0, a_q[WIDTH-1:1]};
               b_q   <= {1'b0, b_q[WIDTH-1:1]};
               br_q  <= br_d;
               cnt_q <= cnt_q + CW'(1);
               // Final bit: publish result on the same edge that raises done.
               if (cnt_q == LAST) begin
                  diff_q  <= r_d;
                  bout_q  <= br_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
